halut_result_collector: RTL and testbench
=========================================

Name: halut_result_collector

Overview:
- Receiving end of the decoder-array result stream (result, valid, m_addr). That stream has no backpressure.
- Buffers each FP32 result with its m_addr in a FIFO. Drains it to the downstream writer over a valid/ready handshake.
- Checks m_addr sequencing and flags lost data. Sits between the decoder array and the output memory writer.

Parameters:
- DecoderUnits, halut_pkg::DecoderUnits, number of decoder units; m_addr wraps at DecoderUnits-1.
- FifoDepth, 32, FIFO entries; power of two, >= 2.
- DecAddrWidth, $clog2(DecoderUnits), m_addr width.
- CntWidth, $clog2(FifoDepth+1), fill-level width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous clear of FIFO, counters and flags.
- in_valid_i  in  1  result beat present; no ready, always sampled.
- in_result_i  in  32  FP32 result.
- in_m_addr_i  in  DecAddrWidth  decoder index of beat.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts head.
- out_result_o  out  32  head result.
- out_m_addr_o  out  DecAddrWidth  head m_addr.
- out_last_o  out  1  head m_addr == DecoderUnits-1.
- fill_o  out  CntWidth  current FIFO occupancy.
- row_cnt_o  out  16  completed rows (wrapping).
- overflow_o  out  1  sticky: a beat was dropped.
- seq_err_o  out  1  sticky: out-of-order m_addr.

Behaviour:
- Reset (async) and clear_i (sync) have the same effect:
  - FIFO empty, expected_addr = 0, row_cnt_o = 0.
  - overflow_o, seq_err_o, out_valid_o all 0.
  - out_result_o and out_m_addr_o = 0 when empty.
- clear_i has priority over push and pop in the same cycle. A beat arriving on that cycle is discarded and no flags are set.
- Push:
  - Occurs when in_valid_i=1 and (fill < FifoDepth, or a pop happens in the same cycle).
  - Writes {result, m_addr} at the write pointer; the pointer increments modulo FifoDepth.
- Pop:
  - Occurs when out_valid_o & out_ready_i; the read pointer increments modulo FifoDepth.
- Latency:
  - A beat pushed at edge N is visible at the head by N+1 if the FIFO was empty.
  - No combinational path from in_* to out_*.
- fill_o: +1 on push-only, -1 on pop-only, unchanged on push+pop or idle.
- Full with in_valid_i=1 and no pop:
  - The beat is dropped and overflow_o is set.
  - expected_addr is still updated from the dropped beat, so the sequence check stays aligned.
- Empty with pop request: impossible, since out_valid_o=0.
- Simultaneous push+pop when empty: not possible at the same entry; the push lands and the head becomes valid next cycle.
- Sequence check, on every in_valid_i beat (including dropped beats):
  - If in_m_addr_i != expected_addr, set seq_err_o. The beat is still stored if there is space.
  - expected_addr_next = (in_m_addr_i == DecoderUnits-1) ? 0 : in_m_addr_i + 1. This resynchronises on the received address.
  - Gaps in in_valid_i do not alter expected_addr.
- Row counter: increments (mod 2^16) on each beat with in_m_addr_i == DecoderUnits-1, whether or not the beat was stored.
- Sticky flags clear only on reset or clear_i.
- Handshake: while out_valid_o=1 and out_ready_i=0, out_result_o, out_m_addr_o and out_last_o are held stable.
- Reset mid-operation: all contents are lost immediately and outputs go to their reset values asynchronously.

Test Plan:
- Reset then idle -> out_valid_o=0, fill_o=0, row_cnt_o=0, flags 0.
- DecoderUnits=16: 16 consecutive beats, m_addr 0..15, results 0x3F800000+i, out_ready_i=1 -> out sequence matches 1 cycle later; out_last_o=1 only on m_addr 15; row_cnt_o=1; seq_err_o=0.
- out_ready_i=0, push 33 beats into depth 32 -> fill_o=32, overflow_o=1, 33rd beat absent; then drain -> first 32 results in order, fill_o returns to 0.
- Full FIFO with in_valid_i=1 and out_ready_i=1 in the same cycle -> no drop, fill_o stays 32, overflow_o=0.
- Beats with m_addr 0,1,3,4 -> seq_err_o=1 after beat 3; all 4 stored; next expected address is 5.
- Mid-stream clear_i with fill_o=5 and in_valid_i=1 -> next cycle fill_o=0, flags 0, row_cnt_o=0, and the beat from the clear cycle is not stored.

Source files
------------

// File: rtl/halut_result_collector.sv
// halut_result_collector
//   Receiving end of the decoder-array result stream. The incoming stream has
//   no backpressure. Each FP32 result is buffered with its m_addr in a FIFO
//   and drained to the output memory writer over a valid/ready handshake.
//   The block also tracks m_addr sequencing, counts completed rows and keeps
//   sticky flags for dropped beats and out-of-order addresses.
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear of FIFO, counters and flags
//   in_valid_i      result beat present (always accepted for checking)
//   in_result_i     FP32 result
//   in_m_addr_i     decoder index of the beat
//   out_valid_o     head entry valid
//   out_ready_i     downstream accepts head
//   out_result_o    head result (0 when empty)
//   out_m_addr_o    head m_addr (0 when empty)
//   out_last_o      head m_addr is the last decoder unit
//   fill_o          FIFO occupancy
//   row_cnt_o       completed rows, wrapping at 2^16
//   overflow_o      sticky: a beat was dropped because the FIFO was full
//   seq_err_o       sticky: an out-of-order m_addr was seen
module halut_result_collector #(
  // Default matches the decoder array's DecoderUnits.
  parameter int DecoderUnits = 16,
  parameter int FifoDepth    = 32,
  parameter int DecAddrWidth = $clog2(DecoderUnits),
  parameter int CntWidth     = $clog2(FifoDepth + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    in_valid_i,
  input  logic [31:0]             in_result_i,
  input  logic [DecAddrWidth-1:0] in_m_addr_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [31:0]             out_result_o,
  output logic [DecAddrWidth-1:0] out_m_addr_o,
  output logic                    out_last_o,
  output logic [CntWidth-1:0]     fill_o,
  output logic [15:0]             row_cnt_o,
  output logic                    overflow_o,
  output logic                    seq_err_o
);

  localparam int PtrWidth = $clog2(FifoDepth);
  localparam logic [DecAddrWidth-1:0] LastAddr = DecAddrWidth'(DecoderUnits - 1);

  logic [31:0]             res_mem_q  [FifoDepth];
  logic [DecAddrWidth-1:0] addr_mem_q [FifoDepth];

  logic [PtrWidth-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]     fill_q, fill_d;
  logic [DecAddrWidth-1:0] exp_addr_q, exp_addr_d;
  logic [15:0]             row_cnt_q, row_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    seq_err_q, seq_err_d;

  logic full, push, pop, beat_last;

  assign out_valid_o = (fill_q != '0);
  assign full        = (fill_q == CntWidth'(FifoDepth));
  assign beat_last   = (in_m_addr_i == LastAddr);

  // clear_i wins over both FIFO operations. A pop frees the head slot on the
  // same edge, so a full FIFO can still take a beat when it is being drained.
  assign pop  = out_valid_o & out_ready_i & ~clear_i;
  assign push = in_valid_i & (~full | pop) & ~clear_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    exp_addr_d = exp_addr_q;
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q;
    seq_err_d  = seq_err_q;

    if (clear_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      exp_addr_d = '0;
      row_cnt_d  = '0;
      overflow_d = 1'b0;
      seq_err_d  = 1'b0;
    end else begin
      // Power-of-two depth: pointer wrap is the natural binary rollover.
      if (push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);

      unique case ({push, pop})
        2'b10:   fill_d = fill_q + CntWidth'(1);
        2'b01:   fill_d = fill_q - CntWidth'(1);
        default: fill_d = fill_q;
      endcase

      // Sequencing and row counting observe every beat, stored or dropped,
      // and resynchronise on the received address.
      if (in_valid_i) begin
        if (in_m_addr_i != exp_addr_q) seq_err_d = 1'b1;
        exp_addr_d = beat_last ? '0 : in_m_addr_i + DecAddrWidth'(1);
        if (beat_last) row_cnt_d = row_cnt_q + 16'd1;
        if (!push) overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      exp_addr_q <= '0;
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      exp_addr_q <= exp_addr_d;
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid. When a
  // full FIFO pushes and pops together, the write lands on the slot being
  // popped, which only changes after the consumer has taken it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      res_mem_q[wr_ptr_q]  <= in_result_i;
      addr_mem_q[wr_ptr_q] <= in_m_addr_i;
    end
  end

  // Head is read straight from storage; it only changes on a pop, so it is
  // stable while the consumer stalls.
  assign out_result_o = out_valid_o ? res_mem_q[rd_ptr_q]  : '0;
  assign out_m_addr_o = out_valid_o ? addr_mem_q[rd_ptr_q] : '0;
  assign out_last_o   = out_valid_o & (addr_mem_q[rd_ptr_q] == LastAddr);

  assign fill_o     = fill_q;
  assign row_cnt_o  = row_cnt_q;
  assign overflow_o = overflow_q;
  assign seq_err_o  = seq_err_q;

endmodule

// File: tb/tb_halut_result_collector.sv
// Bench for halut_result_collector: a hand-computed vector table, directed
// corner sequences, then random traffic against a queue-based reference.
module tb_halut_result_collector;

  localparam int DU    = 16;
  localparam int DEPTH = 32;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_result_i = '0;
  logic [3:0]  in_m_addr_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_result_o;
  logic [3:0]  out_m_addr_o;
  logic        out_last_o;
  logic [5:0]  fill_o;
  logic [15:0] row_cnt_o;
  logic        overflow_o;
  logic        seq_err_o;

  halut_result_collector #(
    .DecoderUnits(DU),
    .FifoDepth   (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .in_valid_i  (in_valid_i),
    .in_result_i (in_result_i),
    .in_m_addr_i (in_m_addr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_result_o(out_result_o),
    .out_m_addr_o(out_m_addr_o),
    .out_last_o  (out_last_o),
    .fill_o      (fill_o),
    .row_cnt_o   (row_cnt_o),
    .overflow_o  (overflow_o),
    .seq_err_o   (seq_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {result, addr} plus scalar bookkeeping.
  typedef struct packed {
    logic [31:0] r;
    logic [3:0]  a;
  } ent_t;
  ent_t mq[$];
  int   m_exp = 0;
  int   m_row = 0;
  bit   m_ovf = 0;
  bit   m_seq = 0;

  task automatic model_reset();
    mq.delete();
    m_exp = 0; m_row = 0; m_ovf = 0; m_seq = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] res, input logic [3:0] a,
                            input logic rdy, input logic clr);
    bit do_pop;
    bit room;
    ent_t e;
    if (clr) begin
      model_reset();
      return;
    end
    do_pop = (mq.size() > 0) && rdy;
    room   = (mq.size() < DEPTH) || do_pop;
    if (do_pop) void'(mq.pop_front());
    if (v) begin
      if (int'(a) != m_exp) m_seq = 1;
      m_exp = (int'(a) == DU - 1) ? 0 : int'(a) + 1;
      if (int'(a) == DU - 1) m_row = (m_row + 1) % 65536;
      if (room) begin
        e.r = res; e.a = a;
        mq.push_back(e);
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic model_check();
    chk("m_valid", 32'(out_valid_o), 32'(mq.size() > 0));
    chk("m_fill", 32'(fill_o), 32'(mq.size()));
    chk("m_row", 32'(row_cnt_o), 32'(m_row));
    chk("m_ovf", 32'(overflow_o), 32'(m_ovf));
    chk("m_seq", 32'(seq_err_o), 32'(m_seq));
    if (mq.size() > 0) begin
      chk("m_res", out_result_o, mq[0].r);
      chk("m_addr", 32'(out_m_addr_o), 32'(mq[0].a));
      chk("m_last", 32'(out_last_o), 32'(int'(mq[0].a) == DU - 1));
    end else begin
      chk("m_res_empty", out_result_o, 32'h0);
      chk("m_addr_empty", 32'(out_m_addr_o), 32'h0);
      chk("m_last_empty", 32'(out_last_o), 32'h0);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, compare at +1.
  task automatic cycle(input logic v, input logic [31:0] res, input logic [3:0] a,
                       input logic rdy, input logic clr);
    in_valid_i  = v;
    in_result_i = res;
    in_m_addr_i = a;
    out_ready_i = rdy;
    clear_i     = clr;
    @(posedge clk_i);
    model_step(v, res, a, rdy, clr);
    #1;
    model_check();
  endtask

  task automatic idle_clear();
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic        v;
    logic [31:0] res;
    logic [3:0]  a;
    logic        rdy;
    logic        clr;
    logic        e_valid;
    logic [31:0] e_res;
    logic [3:0]  e_addr;
    logic        e_last;
    logic [5:0]  e_fill;
    logic [15:0] e_row;
    logic        e_ovf;
    logic        e_seq;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] res, logic [3:0] a, logic rdy, logic clr,
                              logic ev, logic [31:0] er, logic [3:0] ea, logic el,
                              logic [5:0] ef, logic [15:0] erow, logic eo, logic es);
    vec_t t;
    t.v = v; t.res = res; t.a = a; t.rdy = rdy; t.clr = clr;
    t.e_valid = ev; t.e_res = er; t.e_addr = ea; t.e_last = el;
    t.e_fill = ef; t.e_row = erow; t.e_ovf = eo; t.e_seq = es;
    return t;
  endfunction

  localparam logic [31:0] R = 32'h3F80_0000;

  initial begin
    vec_t tbl[13];

    // Sequence 0,1,3,4,5 with stalled consumer, then drains, clear-with-beat,
    // and a row ending on an unexpected address.
    tbl[0]  = mk(0, 0,      0,  0, 1,  0, 0,      0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, R + 0,  0,  0, 0,  1, R + 0,  0,  0, 1, 0, 0, 0);
    tbl[2]  = mk(1, R + 1,  1,  0, 0,  1, R + 0,  0,  0, 2, 0, 0, 0);
    tbl[3]  = mk(1, R + 3,  3,  0, 0,  1, R + 0,  0,  0, 3, 0, 0, 1);
    tbl[4]  = mk(1, R + 4,  4,  0, 0,  1, R + 0,  0,  0, 4, 0, 0, 1);
    tbl[5]  = mk(1, R + 5,  5,  0, 0,  1, R + 0,  0,  0, 5, 0, 0, 1);
    tbl[6]  = mk(0, 0,      0,  1, 0,  1, R + 1,  1,  0, 4, 0, 0, 1);
    tbl[7]  = mk(1, R + 15, 15, 1, 0,  1, R + 3,  3,  0, 4, 1, 0, 1);
    tbl[8]  = mk(1, R + 0,  0,  0, 1,  0, 0,      0,  0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0,      0,  0, 0,  0, 0,      0,  0, 0, 0, 0, 0);
    tbl[10] = mk(1, R + 0,  0,  0, 0,  1, R + 0,  0,  0, 1, 0, 0, 0);
    tbl[11] = mk(1, R + 15, 15, 0, 0,  1, R + 0,  0,  0, 2, 1, 0, 1);
    tbl[12] = mk(0, 0,      0,  1, 0,  1, R + 15, 15, 1, 1, 1, 0, 1);

    // Reset state while held in reset.
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_fill", 32'(fill_o), 32'h0);
    chk("rst_row", 32'(row_cnt_o), 32'h0);
    chk("rst_ovf", 32'(overflow_o), 32'h0);
    chk("rst_seq", 32'(seq_err_o), 32'h0);
    chk("rst_res", out_result_o, 32'h0);
    rst_ni = 1'b1;
    model_reset();
    repeat (2) cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].res, tbl[i].a, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid_o), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_res", i), out_result_o, tbl[i].e_res);
      chk($sformatf("tbl%0d_addr", i), 32'(out_m_addr_o), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_last", i), 32'(out_last_o), 32'(tbl[i].e_last));
      chk($sformatf("tbl%0d_fill", i), 32'(fill_o), 32'(tbl[i].e_fill));
      chk($sformatf("tbl%0d_row", i), 32'(row_cnt_o), 32'(tbl[i].e_row));
      chk($sformatf("tbl%0d_ovf", i), 32'(overflow_o), 32'(tbl[i].e_ovf));
      chk($sformatf("tbl%0d_seq", i), 32'(seq_err_o), 32'(tbl[i].e_seq));
    end

    // One full row streamed with the consumer always ready.
    idle_clear();
    for (int i = 0; i < DU; i++) begin
      cycle(1'b1, R + 32'(i), 4'(i), 1'b1, 1'b0);
      chk("row_head_addr", 32'(out_m_addr_o), 32'(i));
      chk("row_head_res", out_result_o, R + 32'(i));
      chk("row_head_last", 32'(out_last_o), 32'(i == DU - 1));
    end
    chk("row_cnt", 32'(row_cnt_o), 32'd1);
    chk("row_seq", 32'(seq_err_o), 32'd0);

    // Overflow: 33 beats into a stalled 32-deep FIFO, then drain.
    idle_clear();
    for (int i = 0; i < DEPTH + 1; i++)
      cycle(1'b1, 32'h4000_0000 + 32'(i), 4'(i % DU), 1'b0, 1'b0);
    chk("ovf_fill", 32'(fill_o), 32'd32);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_res", out_result_o, 32'h4000_0000 + 32'(i));
      cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    end
    chk("drain_fill", 32'(fill_o), 32'd0);
    chk("drain_valid", 32'(out_valid_o), 32'd0);

    // Full FIFO with simultaneous push and pop: no drop.
    idle_clear();
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 32'h5000_0000 + 32'(i), 4'(i % DU), 1'b0, 1'b0);
    chk("full_fill", 32'(fill_o), 32'd32);
    cycle(1'b1, 32'h5000_0020, 4'(DEPTH % DU), 1'b1, 1'b0);
    chk("pp_fill", 32'(fill_o), 32'd32);
    chk("pp_ovf", 32'(overflow_o), 32'd0);
    chk("pp_head", out_result_o, 32'h5000_0001);

    // Clear mid-stream with fill 5 and a beat on the clear cycle.
    idle_clear();
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h6000_0000 + 32'(i), 4'(i), 1'b0, 1'b0);
    chk("pre_clr_fill", 32'(fill_o), 32'd5);
    cycle(1'b1, 32'h6000_0005, 4'd5, 1'b0, 1'b1);
    chk("clr_fill", 32'(fill_o), 32'd0);
    chk("clr_seq", 32'(seq_err_o), 32'd0);
    chk("clr_row", 32'(row_cnt_o), 32'd0);
    cycle(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    chk("clr_beat_absent", 32'(fill_o), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h7000_0000 + 32'(i), 4'(i), 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 32'd0);
    chk("arst_fill", 32'(fill_o), 32'd0);
    chk("arst_res", out_result_o, 32'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cycle(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);

    // Random traffic against the reference model, with phases of consumer
    // pressure so the FIFO both fills and empties.
    for (int n = 0; n < 3000; n++) begin
      int rdy_pct;
      logic v, rdy, clr;
      logic [3:0] a;
      rdy_pct = ((n / 300) % 3 == 0) ? 20 : ((n / 300) % 3 == 1) ? 90 : 55;
      v   = ($urandom_range(99) < 70);
      rdy = ($urandom_range(99) < rdy_pct);
      clr = ($urandom_range(399) == 0);
      a   = ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'(m_exp);
      cycle(v, $urandom, a, rdy, clr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
